alu_issue_ctrl: RTL

// - Initiator side of the ALU opcode/operand interface: accepts 16-bit instructions (valid/ready), reads

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issue_ctrl_if.sv | 35 +++
 rtl/alu_regfile.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, instruction layout and FSM state type for the ALU issue controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_MOD  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
    } instr_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    function automatic logic is_mulmod(logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MOD);
    endfunction

    function automatic logic is_illegal(logic [3:0] op);
        return op >= 4'b1010;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, register-load, ALU and response signals of the issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned N = 32
) ();
    logic         instr_valid;
    logic         instr_ready;
    logic [15:0]  instr;
    logic         ld_en;
    logic [3:0]   ld_addr;
    logic [N-1:0] ld_data;
    logic [3:0]   alu_opcode;
    logic [N-1:0] alu_operandA;
    logic [N-1:0] alu_operandB;
    logic [N-1:0] alu_result;
    logic         alu_carryout;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_rd;
    logic         rsp_carry;

    // Controller side.
    modport master (
        input  instr_valid, instr, ld_en, ld_addr, ld_data, alu_result, alu_carryout, rsp_ready,
        output instr_ready, alu_opcode, alu_operandA, alu_operandB,
        output rsp_valid, rsp_result, rsp_rd, rsp_carry
    );

    // Environment side: fetch/decode, loader, ALU and response consumer.
    modport slave (
        output instr_valid, instr, ld_en, ld_addr, ld_data, alu_result, alu_carryout, rsp_ready,
        input  instr_ready, alu_opcode, alu_operandA, alu_operandB,
        input  rsp_valid, rsp_result, rsp_rd, rsp_carry
    );
endinterface

// File: rtl/alu_regfile.sv
// Register file: two async read ports (r0 reads 0), a writeback port that beats the load port.
module alu_regfile #(
    parameter int unsigned N    = 32,
    parameter int unsigned REGS = 16,
    parameter int unsigned AW   = $clog2(REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    output logic [N-1:0]  ra_data,
    output logic [N-1:0]  rb_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [N-1:0]  wb_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [N-1:0]  ld_data
);

    logic [N-1:0] regs [REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            // r0 is never written.
            for (int i = 1; i < REGS; i++) begin
                if (wb_en && wb_addr == AW'(i)) regs[i] <= wb_data;
                else if (ld_en && ld_addr == AW'(i)) regs[i] <= ld_data;
            end
        end
    end

    assign ra_data = (ra_addr == '0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == '0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to a combinational ALU, writes back and returns a response.
// Define ALU_ILLEGAL_TRAP_EN to answer opcodes 1010-1111 with all-ones instead of issuing them.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned REGS        = 16,
    parameter int unsigned MULMOD_WAIT = 2
) (
    input logic             clk,
    input logic             rst,
    alu_issue_ctrl_if.master bus
);

    localparam int unsigned CntW = (MULMOD_WAIT > 0) ? $clog2(MULMOD_WAIT + 1) : 1;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [N-1:0]    opa_q, opa_d;
    logic [N-1:0]    opb_q, opb_d;
    logic [N-1:0]    res_q, res_d;
    logic [3:0]      rd_q, rd_d;
    logic            carry_q, carry_d;
    logic            wb_en;
    logic            illegal;
    logic [N-1:0]    ra_data, rb_data;
    instr_t          ins;

    assign ins = instr_t'(bus.instr);

`ifdef ALU_ILLEGAL_TRAP_EN
    assign illegal = is_illegal(ins.op);
`else
    assign illegal = 1'b0;
`endif

    alu_regfile #(
        .N    (N),
        .REGS (REGS),
        .AW   (4)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (ins.ra),
        .rb_addr (ins.rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (bus.alu_result),
        .ld_en   (bus.ld_en),
        .ld_addr (bus.ld_addr),
        .ld_data (bus.ld_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opcode_d = opcode_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        res_d    = res_q;
        rd_d     = rd_q;
        carry_d  = carry_q;
        wb_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    rd_d = ins.rd;
                    if (illegal) begin
                        state_d = RESP;
                        res_d   = '1;
                        carry_d = 1'b0;
                    end else begin
                        state_d  = ISSUE;
                        opcode_d = ins.op;
                        opa_d    = ra_data;
                        opb_d    = rb_data;
                        cnt_d    = is_mulmod(ins.op) ? CntW'(MULMOD_WAIT) : '0;
                    end
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    res_d   = bus.alu_result;
                    // ALU carry is only meaningful for add.
                    carry_d = (opcode_q == OP_ADD) && bus.alu_carryout;
                    wb_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = IDLE;
                    opcode_d = OP_IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opcode_q <= OP_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opcode_q <= opcode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            carry_q  <= carry_d;
        end
    end

    assign bus.instr_ready  = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.alu_opcode   = opcode_q;
    assign bus.alu_operandA = opa_q;
    assign bus.alu_operandB = opb_q;
    assign bus.rsp_result   = res_q;
    assign bus.rsp_rd       = rd_q;
    assign bus.rsp_carry    = carry_q;

endmodule
